intdiv_seqdiv: RTL and testbench
================================

INTDIV_SEQDIV -- requirements
Module: intdiv_seqdiv

Interface
REQ-001 The block SHALL have a parameter N, default 8, giving the two's-complement operand and result width; legal range 4..32.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 in_valid  input  1  the operand pair on x, y is valid.
REQ-005 in_ready  output  1  the block can accept operands.
REQ-006 x  input  N  dividend, signed two's complement.
REQ-007 y  input  N  divisor, signed two's complement.
REQ-008 out_valid  output  1  the result on z, r, ovf, dz is valid.
REQ-009 out_ready  input  1  the consumer takes the result.
REQ-010 z  output  N  quotient, signed.
REQ-011 r  output  N  remainder, signed.
REQ-012 ovf  output  1  overflow: x = -2^(N-1) and y = -1.
REQ-013 dz  output  1  divide by zero; active only when INTDIV_SEQDIV_DIVZERO_EN is defined.

Function
REQ-014 The block SHALL compute z = trunc(x/y) (rounding toward zero) and r = x - z*y, with r zero or carrying the sign of x and |r| < |y|.
REQ-015 The block SHALL have the states IDLE, CALC, FIX and DONE.
REQ-016 in_ready SHALL be 1 only in IDLE; operands are accepted on the edge where in_valid and in_ready are both 1, and x and y are registered at that edge.
REQ-017 Changes on x and y after acceptance SHALL NOT affect the result in progress.
REQ-018 On acceptance the block SHALL go IDLE -> CALC and perform exactly N non-restoring radix-2 iterations on |x| and |y| over an (N+1)-bit partial remainder, one iteration per cycle, controlled by a log2-wide iteration counter.
REQ-019 After the Nth iteration the block SHALL go CALC -> FIX and, in one cycle, restore a negative partial remainder by adding |y|, then apply the signs: negate z if sign(x) differs from sign(y), and negate r if x is negative.
REQ-020 The block SHALL go FIX -> DONE; out_valid SHALL be 1 only in DONE, which is N+2 cycles after the accepting edge.
REQ-021 z, r, ovf and dz SHALL be held stable while out_valid is 1 and out_ready is 0.
REQ-022 On the edge where out_valid and out_ready are both 1, the block SHALL go DONE -> IDLE, so in_ready rises one cycle later; throughput is one division per N+3 cycles at most.
REQ-023 For x = -2^(N-1) and y = -1 the block SHALL produce z = -2^(N-1), r = 0 and ovf = 1 with the normal latency; otherwise ovf = 0.
REQ-024 Intermediate magnitudes SHALL use N+1 bits so that |x| = 2^(N-1) is represented exactly.

Reset
REQ-025 While rst = 1 at a rising edge the block SHALL enter IDLE and clear z, r, ovf, dz, out_valid and the iteration counter to 0; in_ready reads 1 in the cycle after reset.
REQ-026 A reset asserted in CALC, FIX or DONE SHALL abort the operation with no result delivered.
REQ-027 in_valid SHALL be ignored in any cycle where rst = 1.

Configuration
REQ-028 With the macro INTDIV_SEQDIV_DIVZERO_EN defined, y = 0 at acceptance SHALL make the block go IDLE -> DONE directly (out_valid one cycle after the accepting edge) with z = all ones, r = x, dz = 1 and ovf = 0.
REQ-029 With INTDIV_SEQDIV_DIVZERO_EN undefined, dz SHALL be tied to 0 and y = 0 SHALL follow the normal N+2-cycle path; z and r are then deterministic but unspecified.

Verification (N=8)
REQ-030 x=7, y=3, out_ready=1 -> z=2, r=1, ovf=0, with out_valid exactly 10 cycles after acceptance.
REQ-031 x=-7, y=3 -> z=-2, r=-1; x=7, y=-3 -> z=-2, r=1; x=-7, y=-3 -> z=2, r=-1.
REQ-032 x=-128, y=-1 -> z=-128, r=0, ovf=1; x=-128, y=1 -> z=-128, r=0, ovf=0.
REQ-033 After a result is presented, hold out_ready=0 for 5 cycles while toggling x and y -> z, r and out_valid stay stable and in_ready stays 0; then out_ready=1 -> in_ready=1 on the next cycle.
REQ-034 Accept x=100, y=7, then assert rst in the 4th CALC cycle -> out_valid never rises, and in_ready=1 after reset; the next division, 100/7, returns z=14, r=2.
REQ-035 With INTDIV_SEQDIV_DIVZERO_EN defined, x=5, y=0 -> one cycle later out_valid=1, z=8'hFF, r=5, dz=1; with it undefined -> dz=0 and out_valid after 10 cycles.

Source files
------------

// File: rtl/intdiv_seqdiv.sv
// -----------------------------------------------------------------------------
// intdiv_seqdiv
//
// Sequential signed integer divider. It computes z = trunc(x/y) and
// r = x - z*y, so the quotient rounds toward zero and the remainder takes
// the sign of the dividend. Internally it runs N non-restoring radix-2
// iterations on the operand magnitudes, one iteration per clock.
//
// Build option:
//   INTDIV_SEQDIV_DIVZERO_EN - when defined, y == 0 at acceptance skips the
//   iterations and returns z = all ones, r = x, dz = 1 on the next cycle.
//   When undefined, dz is always 0 and y == 0 runs the normal iteration path.
//
// Parameters:
//   N          operand/result width, two's complement, 4..32
//
// Ports:
//   clk        clock; all state updates on the rising edge
//   rst        synchronous active-high reset
//   in_valid   operand pair on x/y is valid
//   in_ready   divider is idle and can accept operands
//   x, y       dividend, divisor (signed)
//   out_valid  result on z/r/ovf/dz is valid
//   out_ready  consumer takes the result
//   z, r       quotient, remainder (signed)
//   ovf        x = -2^(N-1) and y = -1 (quotient wraps to -2^(N-1))
//   dz         divide by zero (build option only, otherwise 0)
//
// State table:
//   state  | meaning
//   IDLE   | waiting for operands, in_ready = 1
//   CALC   | N non-restoring iterations, one per cycle
//   FIX    | restore remainder, apply result signs
//   DONE   | result presented, out_valid = 1 until out_ready
// -----------------------------------------------------------------------------
module intdiv_seqdiv #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] z,
  output logic [N-1:0] r,
  output logic         ovf,
  output logic         dz
);

  localparam int CW = $clog2(N);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N:0]    p_q, p_d;      // signed partial remainder
  logic [N-1:0]  q_q, q_d;      // dividend magnitude shifting out, quotient shifting in
  logic [N:0]    ay_q, ay_d;    // divisor magnitude, zero-extended
  logic          sx_q, sx_d;
  logic          sy_q, sy_d;
  logic          ovf_pend_q, ovf_pend_d;
  logic [N-1:0]  z_q, z_d;
  logic [N-1:0]  r_q, r_d;
  logic          ovf_q, ovf_d;
  logic          dz_q, dz_d;

  logic          accept;
  logic [N-1:0]  x_mag;
  logic [N-1:0]  y_mag;
  logic          ovf_case;
  logic [N:0]    p_sh;
  logic [N:0]    p_step;
  logic [N-1:0]  q_step;
  logic [N-1:0]  rem;
  logic [N-1:0]  z_fix;
  logic [N-1:0]  r_fix;

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign accept    = in_valid && in_ready;

  // Magnitudes read as unsigned N-bit values: -2^(N-1) negates to
  // 2^(N-1), which is exact when the MSB is treated as a magnitude bit.
  assign x_mag = x[N-1] ? (~x + N'(1)) : x;
  assign y_mag = y[N-1] ? (~y + N'(1)) : y;

  assign ovf_case = (x == {1'b1, {(N-1){1'b0}}}) && (y == {N{1'b1}});

  // One non-restoring step: shift the next dividend bit into the partial
  // remainder, then add or subtract |y| depending on the current sign.
  // The quotient bit is 1 whenever the new partial remainder is non-negative.
  assign p_sh   = {p_q[N-1:0], q_q[N-1]};
  assign p_step = p_q[N] ? (p_sh + ay_q) : (p_sh - ay_q);
  assign q_step = {q_q[N-2:0], ~p_step[N]};

  // The restored remainder is below |y| <= 2^(N-1), so N bits of modular
  // arithmetic give it exactly.
  assign rem   = p_q[N-1:0] + (p_q[N] ? ay_q[N-1:0] : {N{1'b0}});
  assign z_fix = (sx_q ^ sy_q) ? (~q_q + N'(1)) : q_q;
  assign r_fix = sx_q ? (~rem + N'(1)) : rem;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    p_d        = p_q;
    q_d        = q_q;
    ay_d       = ay_q;
    sx_d       = sx_q;
    sy_d       = sy_q;
    ovf_pend_d = ovf_pend_q;
    z_d        = z_q;
    r_d        = r_q;
    ovf_d      = ovf_q;
    dz_d       = dz_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d    = S_CALC;
          cnt_d      = CW'(N - 1);
          p_d        = '0;
          q_d        = x_mag;
          ay_d       = {1'b0, y_mag};
          sx_d       = x[N-1];
          sy_d       = y[N-1];
          ovf_pend_d = ovf_case;
`ifdef INTDIV_SEQDIV_DIVZERO_EN
          if (y == '0) begin
            state_d = S_DONE;
            z_d     = {N{1'b1}};
            r_d     = x;
            ovf_d   = 1'b0;
            dz_d    = 1'b1;
          end
`endif
        end
      end

      S_CALC: begin
        p_d = p_step;
        q_d = q_step;
        if (cnt_q == '0) begin
          state_d = S_FIX;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      S_FIX: begin
        z_d     = z_fix;
        r_d     = r_fix;
        ovf_d   = ovf_pend_q;
        dz_d    = 1'b0;
        state_d = S_DONE;
      end

      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      p_q        <= '0;
      q_q        <= '0;
      ay_q       <= '0;
      sx_q       <= 1'b0;
      sy_q       <= 1'b0;
      ovf_pend_q <= 1'b0;
      z_q        <= '0;
      r_q        <= '0;
      ovf_q      <= 1'b0;
      dz_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      p_q        <= p_d;
      q_q        <= q_d;
      ay_q       <= ay_d;
      sx_q       <= sx_d;
      sy_q       <= sy_d;
      ovf_pend_q <= ovf_pend_d;
      z_q        <= z_d;
      r_q        <= r_d;
      ovf_q      <= ovf_d;
      dz_q       <= dz_d;
    end
  end

  assign z   = z_q;
  assign r   = r_q;
  assign ovf = ovf_q;

`ifdef INTDIV_SEQDIV_DIVZERO_EN
  assign dz = dz_q;
`else
  // dz_q never leaves 0 in this build; the port is tied off directly.
  assign dz = 1'b0;
`endif

endmodule

// File: tb/tb_intdiv_seqdiv.sv
// -----------------------------------------------------------------------------
// tb_intdiv_seqdiv
//
// Self-checking bench for intdiv_seqdiv (N = 8). Stimulus pushes the
// hand-computed result of each division into a scoreboard queue; a monitor
// pops and compares on every output handshake.
// -----------------------------------------------------------------------------
module tb_intdiv_seqdiv;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] x;
  logic [N-1:0] y;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] z;
  logic [N-1:0] r;
  logic         ovf;
  logic         dz;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [N-1:0] z;
    logic [N-1:0] r;
    logic         ovf;
    logic         dz;
    logic         chk_zr;
  } exp_t;

  exp_t sb[$];

  intdiv_seqdiv #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .z         (z),
    .r         (r),
    .ovf       (ovf),
    .dz        (dz)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: a result is consumed on the edge following a negedge where
  // out_valid and out_ready are both high.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_result: got z=%0h r=%0h with empty scoreboard", z, r);
        end else begin
          e = sb.pop_front();
          if (e.chk_zr) begin
            check("z", 32'(z), 32'(e.z));
            check("r", 32'(r), 32'(e.r));
          end
          check("ovf", 32'(ovf), 32'(e.ovf));
          check("dz",  32'(dz),  32'(e.dz));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic wait_ready();
    int k = 0;
    @(negedge clk);
    while (!in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("in_ready_wait", 32'(in_ready), 32'd1);
  endtask

  // Issue one division, push its expected result, and measure how many
  // cycles after the accepting edge out_valid is first seen.
  task automatic issue(input int xa, input int ya, input int ez, input int er,
                       input int eo, input int ed, input int czr, input int lat_exp);
    exp_t e;
    int   lat;
    wait_ready();
    x        = xa[N-1:0];
    y        = ya[N-1:0];
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    x        = 8'h55;
    y        = 8'h11;
    e.z      = ez[N-1:0];
    e.r      = er[N-1:0];
    e.ovf    = eo[0];
    e.dz     = ed[0];
    e.chk_zr = czr[0];
    sb.push_back(e);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 40);
    check("latency", 32'(lat), 32'(lat_exp));
  endtask

  task automatic run_div(input int xa, input int ya, input int ez, input int er, input int eo);
    int k = 0;
    issue(xa, ya, ez, er, eo, 0, 1, N + 2);
    while (out_valid && k < 40) begin
      @(negedge clk);
      k++;
    end
    check("out_valid_drop", 32'(out_valid), 32'd0);
  endtask

  initial begin
    int saw;
    int k;

    // Reset with in_valid high: the request must be ignored.
    rst       = 1'b1;
    in_valid  = 1'b1;
    x         = 8'd5;
    y         = 8'd1;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_z",         32'(z),         32'd0);
    check("rst_r",         32'(r),         32'd0);
    check("rst_ovf",       32'(ovf),       32'd0);
    check("rst_dz",        32'(dz),        32'd0);
    @(negedge clk);
    check("idle_out_valid", 32'(out_valid), 32'd0);

    // Directed vectors: x, y, z, r, ovf
    run_div(   7,    3,    2,   1, 0);
    run_div(  -7,    3,   -2,  -1, 0);
    run_div(   7,   -3,   -2,   1, 0);
    run_div(  -7,   -3,    2,  -1, 0);
    run_div(-128,   -1, -128,   0, 1);
    run_div(-128,    1, -128,   0, 0);
    run_div( 127, -128,    0, 127, 0);
    run_div(-128, -128,    1,   0, 0);
    run_div(-128,    7,  -18,  -2, 0);
    run_div(   0,    5,    0,   0, 0);
    run_div( 127,    1,  127,   0, 0);

    // Backpressure: result must stay put while out_ready is low.
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    issue(20, 6, 3, 2, 0, 0, 1, N + 2);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      x = 8'($urandom);
      y = 8'($urandom);
      @(negedge clk);
      check("stall_out_valid", 32'(out_valid), 32'd1);
      check("stall_z",         32'(z),         32'd3);
      check("stall_r",         32'(r),         32'd2);
      check("stall_in_ready",  32'(in_ready),  32'd0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("release_in_ready",  32'(in_ready),  32'd1);
    check("release_out_valid", 32'(out_valid), 32'd0);

    // Abort: reset in the 4th CALC cycle of 100/7.
    wait_ready();
    x        = 8'd100;
    y        = 8'd7;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_z",        32'(z),        32'd0);
    check("abort_r",        32'(r),        32'd0);
    saw = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (out_valid) saw = 1;
    end
    check("abort_no_result", 32'(saw), 32'd0);
    run_div(100, 7, 14, 2, 0);

    // Divide by zero
`ifdef INTDIV_SEQDIV_DIVZERO_EN
    issue(5, 0, 8'hFF, 5, 0, 1, 1, 1);
`else
    issue(5, 0, 0, 0, 0, 0, 0, N + 2);
`endif
    k = 0;
    while (out_valid && k < 40) begin
      @(negedge clk);
      k++;
    end

    k = 0;
    while (sb.size() != 0 && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
